// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation codes, FSM states and op-class helpers.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SLL  = 5'b00001,
        OP_SLT  = 5'b00010,
        OP_SLTU = 5'b00011,
        OP_XOR  = 5'b00100,
        OP_SRL  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_AND  = 5'b00111,
        OP_SUB  = 5'b01000,
        OP_SRA  = 5'b01101,
        OP_BEQ  = 5'b10000,
        OP_BNE  = 5'b10001,
        OP_BLT  = 5'b10100,
        OP_BGE  = 5'b10101,
        OP_BLTU = 5'b10110,
        OP_BGEU = 5'b10111,
        OP_PASS = 5'b11111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_state_e;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves value by 0..SHIFT_STEP positions.
module alu_shift_step #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic [XLEN-1:0]                    value_i,
    input  logic                               right_i,
    input  logic                               arith_i,
    input  logic [$clog2(SHIFT_STEP+1)-1:0]    amount_i,
    output logic [XLEN-1:0]                    result_o
);

    always_comb begin
        result_o = value_i;
        if (!right_i) begin
            result_o = value_i << amount_i;
        end else if (arith_i) begin
            result_o = $unsigned($signed(value_i) >>> amount_i);
        end else begin
            result_o = value_i >> amount_i;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked integer ALU with branch resolution; shifts iterate SHIFT_STEP bits per cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            branch_o,
    output logic            illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned AMW = $clog2(SHIFT_STEP + 1);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] val_q, result_q;
    logic [SHW-1:0]  rem_q, rem_next;
    logic [4:0]      op_q;
    logic            branch_q, illegal_q;

    logic [SHW-1:0]  sh;
    logic            accept, long_shift;
    logic [XLEN-1:0] res_d, shifted;
    logic            br_d, ill_d;
    logic [AMW-1:0]  step;

    assign sh         = b_i[SHW-1:0];
    assign ready_o    = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept     = valid_i && ready_o;
    assign long_shift = is_shift(op_i) && (sh != '0);
    assign valid_o    = (state_q == DONE);
    assign result_o   = result_q;
    assign branch_o   = branch_q;
    assign illegal_o  = illegal_q;

    always_comb begin
        res_d = '0;
        br_d  = 1'b0;
        ill_d = 1'b0;
        case (op_i)
            OP_ADD:                  res_d = a_i + b_i;
            OP_SUB:                  res_d = a_i - b_i;
            OP_SLL, OP_SRL, OP_SRA:  res_d = a_i;  // only taken directly when sh == 0
            OP_SLT:                  res_d = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU:                 res_d = {{(XLEN-1){1'b0}}, a_i < b_i};
            OP_XOR:                  res_d = a_i ^ b_i;
            OP_OR:                   res_d = a_i | b_i;
            OP_AND:                  res_d = a_i & b_i;
            OP_PASS:                 res_d = a_i;
            OP_BEQ:                  br_d  = (a_i == b_i);
            OP_BNE:                  br_d  = (a_i != b_i);
            OP_BLT:                  br_d  = ($signed(a_i) < $signed(b_i));
            OP_BGE:                  br_d  = ($signed(a_i) >= $signed(b_i));
            OP_BLTU:                 br_d  = (a_i < b_i);
            OP_BGEU:                 br_d  = (a_i >= b_i);
            default:                 ill_d = 1'b1;
        endcase
        if (is_branch(op_i)) begin
            res_d = {{(XLEN-1){1'b0}}, br_d};
        end
    end

    always_comb begin
        if (int'(rem_q) >= SHIFT_STEP) begin
            step = AMW'(SHIFT_STEP);
        end else begin
            step = AMW'(rem_q);
        end
        rem_next = rem_q - SHW'(step);
    end

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .value_i  (val_q),
        .right_i  (op_q != OP_SLL),
        .arith_i  (op_q == OP_SRA),
        .amount_i (step),
        .result_o (shifted)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = long_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    if (valid_i) begin
                        state_d = long_shift ? SHIFT : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q     <= '0;
            rem_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            if (long_shift) begin
                val_q <= a_i;
                rem_q <= sh;
                op_q  <= op_i;
            end else begin
                result_q  <= res_d;
                branch_q  <= br_d;
                illegal_q <= ill_d;
            end
        end else if (state_q == SHIFT) begin
            val_q <= shifted;
            rem_q <= rem_next;
            if (rem_next == '0) begin
                result_q  <= shifted;
                branch_q  <= 1'b0;
                illegal_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (XLEN=32, SHIFT_STEP=8) with hand-computed expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        branch_o;
    logic        illegal_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    alu_pipe #(
        .XLEN       (32),
        .SHIFT_STEP (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .branch_o  (branch_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one op at the current negedge and waits (bounded) for valid_o.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int unsigned lat, output int unsigned ready_low);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i   = 1'b0;
        lat       = 1;
        ready_low = 0;
        while (!valid_o && lat < 20) begin
            if (!ready_o) ready_low++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br,
                       input int unsigned exp_lat);
        int unsigned lat, rl;
        run_op(op, a, b, lat, rl);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_br"}, {31'b0, branch_o}, {31'b0, exp_br});
    endtask

    initial begin
        int unsigned lat, rl;
        bit stale;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        ready_i = 1'b1;

        @(negedge clk_i);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_branch", {31'b0, branch_o}, 32'd0);
        check("rst_illegal", {31'b0, illegal_o}, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        vec("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1);
        check("add_illegal", {31'b0, illegal_o}, 32'd0);

        run_op(OP_SRA, 32'h8000_0000, 32'd31, lat, rl);
        check("sra31_lat", lat, 32'd5);
        check("sra31_ready_low", rl, 32'd4);
        check("sra31_res", result_o, 32'hFFFF_FFFF);

        vec("blt", OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1);
        vec("bltu", OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        vec("bge_eq", OP_BGE, 32'd5, 32'd5, 32'd1, 1'b1, 1);
        vec("beq_ne", OP_BEQ, 32'd5, 32'd6, 32'd0, 1'b0, 1);
        vec("bne", OP_BNE, 32'd5, 32'd6, 32'd1, 1'b1, 1);
        vec("bgeu", OP_BGEU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        vec("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
        vec("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        vec("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        vec("pass", OP_PASS, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1);
        // b=0x24: only the low 5 bits (4) count
        vec("sll_hibits", OP_SLL, 32'd1, 32'h0000_0024, 32'h0000_0010, 1'b0, 2);
        vec("srl_sh0", OP_SRL, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 1'b0, 1);
        vec("srl9", OP_SRL, 32'h8000_0000, 32'd9, 32'h0040_0000, 1'b0, 3);
        vec("sra_pos", OP_SRA, 32'h4000_0000, 32'd17, 32'h0000_2000, 1'b0, 4);

        // Back-to-back XOR then AND
        op_i = OP_XOR; a_i = 32'hFF00_FF00; b_i = 32'h0F0F_0F0F; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("b2b_xor_valid", {31'b0, valid_o}, 32'd1);
        check("b2b_xor_res", result_o, 32'hF00F_F00F);
        check("b2b_ready", {31'b0, ready_o}, 32'd1);
        op_i = OP_AND; a_i = 32'hF0F0_F0F0; b_i = 32'hFF00_FF00;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("b2b_and_valid", {31'b0, valid_o}, 32'd1);
        check("b2b_and_res", result_o, 32'hF000_F000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("hold_valid", {31'b0, valid_o}, 32'd1);
            check("hold_res", result_o, 32'hF000_F000);
            check("hold_ready", {31'b0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("drain_idle", {31'b0, valid_o}, 32'd0);

        vec("illegal", 5'b01010, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 1'b0, 1);
        check("illegal_flag", {31'b0, illegal_o}, 32'd1);
        vec("or_after_ill", OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1);
        check("or_illegal", {31'b0, illegal_o}, 32'd0);

        // Reset during SHIFT of SLL by 20
        op_i = OP_SLL; a_i = 32'd1; b_i = 32'd20; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("mid_shift_ready", {31'b0, ready_o}, 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        check("arst_branch", {31'b0, branch_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (valid_o) stale = 1'b1;
        end
        check("post_rst_ready", {31'b0, ready_o}, 32'd1);
        check("post_rst_no_stale", {31'b0, stale}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
